// File: rtl/program_loader.sv
// Boot loader: takes a LEN/payload/CSUM byte stream, writes the payload
// to RAM at LOAD_BASE, then hands RAM to the CPU and releases its reset.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_data    stream byte in; in_ready high when accepting
//   cpu_ram_*           CPU-side RAM write port (used only in RUN)
//   ram_*               RAM write port (loader or CPU)
//   cpu_rst_n           CPU reset, released only in RUN
//   load_done/load_err  status: running / last checksum failed
module program_loader #(
  parameter logic [7:0] LOAD_BASE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] cpu_ram_data,
  input  logic [7:0] cpu_ram_addr,
  input  logic       cpu_ram_we,
  output logic [7:0] ram_data,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic       cpu_rst_n,
  output logic       load_done,
  output logic       load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] n_q, n_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       cpu_rst_n_q, cpu_rst_n_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       accept;
  logic       run;

  assign run      = (state_q == S_RUN);
  assign in_ready = rst_n && !run;
  assign accept   = in_valid && in_ready;

  // RAM belongs to the CPU once the program is running.
  assign ram_we    = run ? cpu_ram_we   : we_q;
  assign ram_addr  = run ? cpu_ram_addr : addr_q;
  assign ram_data  = run ? cpu_ram_data : data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (accept) begin
          // LEN of zero encodes a full 256-byte payload.
          n_d     = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          cnt_d   = 9'd0;
          sum_d   = 8'h00;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = LOAD_BASE + cnt_q[7:0];
          data_d = in_data;
          sum_d  = sum_q + in_data;
          cnt_d  = cnt_q + 9'd1;
          if (cnt_d == n_q) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d     = S_RUN;
            cpu_rst_n_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= 9'd0;
      cnt_q       <= 9'd0;
      sum_q       <= 8'h00;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule
